// File: rtl/gem_trig_link_pkg.sv
// rtl/gem_trig_link_pkg.sv - GEM trigger link frame constants shared by TX and RX
package gem_trig_link_pkg;

  localparam logic [7:0] K_NORM    = 8'hBC;
  localparam logic [7:0] K_BC0     = 8'hF7;
  localparam logic [7:0] K_OVF     = 8'h1C;
  localparam logic [7:0] K_BC0_OVF = 8'hFC;

  localparam int WORDS_PER_BX = 4;
  localparam int N_CLUSTERS   = 4;
  localparam int CLUSTER_W    = 14;
  localparam logic [CLUSTER_W-1:0] INVALID_CLUSTER = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCKED
  } align_state_t;

  function automatic logic is_marker(input logic [7:0] b);
    return (b == K_NORM) || (b == K_BC0) || (b == K_OVF) || (b == K_BC0_OVF);
  endfunction

endpackage

// File: rtl/trigger_link_rx_align.sv
// rtl/trigger_link_rx_align.sv - word phase counter and HUNT/SYNC/LOCKED frame alignment
module trigger_link_rx_align
  import gem_trig_link_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic        clk_160,
  input  logic        reset_n,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_charisk,
  input  logic [1:0]  rx_code_err,
  output logic [1:0]  phase,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_good
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  align_state_t  state, state_next;
  logic [1:0]    phase_next;
  logic [GW-1:0] good_cnt, good_next;
  logic [BW-1:0] bad_cnt, bad_next;
  logic          ok_acc, ok_next;
  logic          marker_word, data_word_ok, word_ok;

  assign marker_word  = (rx_charisk == 2'b01) && (rx_code_err == 2'b00) && is_marker(rx_data[7:0]);
  assign data_word_ok = (rx_charisk == 2'b00) && (rx_code_err == 2'b00);
  assign word_ok      = (phase == 2'd0) ? marker_word : data_word_ok;

  // ok_acc holds the verdict on the words of the current frame already seen
  assign frame_done = (state != ST_HUNT) && (phase == 2'd3);
  assign frame_good = ok_acc && word_ok;
  assign locked     = (state == ST_LOCKED);

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HUNT;
      phase    <= 2'd0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      ok_acc   <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
      ok_acc   <= ok_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase + 2'd1;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    ok_next    = (phase == 2'd0) ? word_ok : (ok_acc && word_ok);
    case (state)
      ST_HUNT: begin
        // phase parks at 0 so the next marker word is taken as w0
        phase_next = 2'd0;
        if (marker_word) begin
          phase_next = 2'd1;
          good_next  = GW'(1);
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (frame_done) begin
          if (!frame_good) begin
            state_next = ST_HUNT;
          end else if (good_cnt >= GW'(LOCK_COUNT)) begin
            state_next = ST_LOCKED;
            bad_next   = '0;
          end else begin
            good_next = good_cnt + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (frame_done) begin
          if (frame_good) begin
            bad_next = '0;
          end else if (bad_cnt + BW'(1) >= BW'(UNLOCK_COUNT)) begin
            bad_next   = '0;
            state_next = ST_HUNT;
          end else begin
            bad_next = bad_cnt + BW'(1);
          end
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

endmodule

// File: rtl/trigger_link_rx_decoder.sv
// rtl/trigger_link_rx_decoder.sv - GEM trigger link receiver: frame decode, BX check, error counters
module trigger_link_rx_decoder
  import gem_trig_link_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_COUNT  = 4,
  parameter int BX_PER_ORBIT  = 3564,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_160,
  input  logic                     reset_n,
  input  logic [15:0]              rx_data,
  input  logic [1:0]               rx_charisk,
  input  logic [1:0]               rx_code_err,
  input  logic                     cnt_reset,
  output logic [CLUSTER_W-1:0]     cluster0,
  output logic [CLUSTER_W-1:0]     cluster1,
  output logic [CLUSTER_W-1:0]     cluster2,
  output logic [CLUSTER_W-1:0]     cluster3,
  output logic [3:0]               valid_clusters,
  output logic                     frame_strobe,
  output logic                     bc0,
  output logic                     overflow,
  output logic [11:0]              bxn,
  output logic                     locked,
  output logic                     frame_err,
  output logic                     bx_err,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] bx_err_cnt
);

  logic [1:0]  phase;
  logic        align_locked, frame_done, frame_good;
  logic [7:0]  marker_q, d0_q;
  logic [15:0] w1_q, w2_q;
  logic [55:0] frame_data;

  logic [N_CLUSTERS-1:0][CLUSTER_W-1:0] clus_new, clus_q;
  logic [N_CLUSTERS-1:0]                valid_new;

  logic        strobe, good_strobe, bad_strobe, is_bc0, is_ovf, bc0_frame, bx_err_next, bc0_seen;
  logic [11:0] bxn_next;

  trigger_link_rx_align #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_align (
    .clk_160    (clk_160),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_charisk (rx_charisk),
    .rx_code_err(rx_code_err),
    .phase      (phase),
    .locked     (align_locked),
    .frame_done (frame_done),
    .frame_good (frame_good)
  );

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      marker_q <= '0;
      d0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
    end else begin
      case (phase)
        2'd0: begin
          marker_q <= rx_data[7:0];
          d0_q     <= rx_data[15:8];
        end
        2'd1:    w1_q <= rx_data;
        2'd2:    w2_q <= rx_data;
        default: ;
      endcase
    end
  end

  // w3 is taken straight from the input so outputs land one cycle after w3
  assign frame_data = {rx_data, w2_q, w1_q, d0_q};

  always_comb begin
    clus_new  = '0;
    valid_new = '0;
    for (int k = 0; k < N_CLUSTERS; k++) begin
      clus_new[k]  = frame_data[k*CLUSTER_W +: CLUSTER_W];
      valid_new[k] = (clus_new[k][10:9] != 2'b11);
    end
  end

  assign strobe      = align_locked && frame_done;
  assign good_strobe = strobe && frame_good;
  assign bad_strobe  = strobe && !frame_good;
  assign is_bc0      = (marker_q == K_BC0) || (marker_q == K_BC0_OVF);
  assign is_ovf      = (marker_q == K_OVF) || (marker_q == K_BC0_OVF);
  assign bc0_frame   = good_strobe && is_bc0;
  assign bx_err_next = bc0_frame && bc0_seen && (bxn != 12'(BX_PER_ORBIT - 1));
  assign bxn_next    = (bc0_frame || bxn == 12'(BX_PER_ORBIT - 1)) ? 12'd0 : bxn + 12'd1;

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      clus_q         <= {N_CLUSTERS{INVALID_CLUSTER}};
      valid_clusters <= '0;
      bc0            <= 1'b0;
      overflow       <= 1'b0;
      frame_strobe   <= 1'b0;
      frame_err      <= 1'b0;
      bx_err         <= 1'b0;
      bxn            <= '0;
      bc0_seen       <= 1'b0;
    end else begin
      frame_strobe <= strobe;
      frame_err    <= bad_strobe;
      bx_err       <= bx_err_next;
      if (good_strobe) begin
        clus_q         <= clus_new;
        valid_clusters <= valid_new;
        bc0            <= is_bc0;
        overflow       <= is_ovf;
      end else if (bad_strobe || !align_locked) begin
        clus_q         <= {N_CLUSTERS{INVALID_CLUSTER}};
        valid_clusters <= '0;
        bc0            <= 1'b0;
        overflow       <= 1'b0;
      end
      if (!align_locked) begin
        bxn      <= '0;
        bc0_seen <= 1'b0;
      end else if (strobe) begin
        bxn <= bxn_next;
        if (bc0_frame) bc0_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_cnt <= '0;
      bx_err_cnt    <= '0;
    end else if (cnt_reset) begin
      frame_err_cnt <= '0;
      bx_err_cnt    <= '0;
    end else begin
      if (bad_strobe && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + ERR_CNT_WIDTH'(1);
      if (bx_err_next && bx_err_cnt != '1)   bx_err_cnt    <= bx_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign cluster0 = clus_q[0];
  assign cluster1 = clus_q[1];
  assign cluster2 = clus_q[2];
  assign cluster3 = clus_q[3];
  assign locked   = align_locked;

endmodule

// File: tb/tb_trigger_link_rx_decoder.sv
// tb/tb_trigger_link_rx_decoder.sv - directed self-checking bench for trigger_link_rx_decoder
module tb_trigger_link_rx_decoder;
  import gem_trig_link_pkg::*;

  logic        clk_160 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_charisk = '0;
  logic [1:0]  rx_code_err = '0;
  logic        cnt_reset = 1'b0;
  logic [13:0] cluster0, cluster1, cluster2, cluster3;
  logic [3:0]  valid_clusters;
  logic        frame_strobe, bc0, overflow, locked, frame_err, bx_err;
  logic [11:0] bxn;
  logic [15:0] frame_err_cnt, bx_err_cnt;

  int passed = 0;
  int total  = 0;

  // clusters {c3,c2,c1,c0}: A all valid, B has cluster2[10:9] = 2'b11
  localparam logic [55:0] DATA_A = {14'h3000, 14'h0567, 14'h1234, 14'h0BCD};
  localparam logic [55:0] DATA_B = {14'h3000, 14'h0600, 14'h1234, 14'h0BCD};

  always #5 clk_160 = ~clk_160;

  trigger_link_rx_decoder dut (
    .clk_160       (clk_160),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_charisk    (rx_charisk),
    .rx_code_err   (rx_code_err),
    .cnt_reset     (cnt_reset),
    .cluster0      (cluster0),
    .cluster1      (cluster1),
    .cluster2      (cluster2),
    .cluster3      (cluster3),
    .valid_clusters(valid_clusters),
    .frame_strobe  (frame_strobe),
    .bc0           (bc0),
    .overflow      (overflow),
    .bxn           (bxn),
    .locked        (locked),
    .frame_err     (frame_err),
    .bx_err        (bx_err),
    .frame_err_cnt (frame_err_cnt),
    .bx_err_cnt    (bx_err_cnt)
  );

  task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic [1:0] e, input logic cr);
    rx_data     = d;
    rx_charisk  = k;
    rx_code_err = e;
    cnt_reset   = cr;
    @(posedge clk_160);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] mk, input logic [55:0] d, input logic [3:0] err, input logic cr);
    send_word({d[7:0], mk}, 2'b01, {2{err[0]}}, 1'b0);
    send_word(d[23:8],      2'b00, {2{err[1]}}, 1'b0);
    send_word(d[39:24],     2'b00, {2{err[2]}}, 1'b0);
    send_word(d[55:40],     2'b00, {2{err[3]}}, cr);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_160);
    #1;
    total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", locked); else passed++;
    total++; if (frame_strobe !== 1'b0) $display("FAIL rst_strobe: got %0b want 0", frame_strobe); else passed++;
    total++; if (cluster0 !== 14'h3FFF) $display("FAIL rst_cluster0: got %h want 3fff", cluster0); else passed++;
    total++; if (valid_clusters !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", valid_clusters); else passed++;
    total++; if (bxn !== 12'd0) $display("FAIL rst_bxn: got %0d want 0", bxn); else passed++;
    total++; if (frame_err_cnt !== 16'd0) $display("FAIL rst_ferr_cnt: got %0d want 0", frame_err_cnt); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 8; i++) begin
      send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
      if (i == 7) begin
        total++; if (locked !== 1'b0) $display("FAIL lock_early: got %0b want 0", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b1) $display("FAIL lock_rise: got %0b want 1", locked); else passed++;
    total++; if (frame_strobe !== 1'b0) $display("FAIL lock_no_strobe: got %0b want 0", frame_strobe); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (frame_strobe !== 1'b1) $display("FAIL first_strobe: got %0b want 1", frame_strobe); else passed++;
    total++; if (cluster0 !== 14'h0BCD) $display("FAIL cluster0: got %h want 0bcd", cluster0); else passed++;
    total++; if (cluster1 !== 14'h1234) $display("FAIL cluster1: got %h want 1234", cluster1); else passed++;
    total++; if (cluster2 !== 14'h0567) $display("FAIL cluster2: got %h want 0567", cluster2); else passed++;
    total++; if (cluster3 !== 14'h3000) $display("FAIL cluster3: got %h want 3000", cluster3); else passed++;
    total++; if (valid_clusters !== 4'b1111) $display("FAIL valid_a: got %b want 1111", valid_clusters); else passed++;
    total++; if (bxn !== 12'd1) $display("FAIL bxn_first: got %0d want 1", bxn); else passed++;
    total++; if (bc0 !== 1'b0 || overflow !== 1'b0) $display("FAIL flags_norm: got bc0=%0b ovf=%0b want 0 0", bc0, overflow); else passed++;
    send_word({DATA_A[7:0], K_NORM}, 2'b01, 2'b00, 1'b0);
    total++; if (frame_strobe !== 1'b0) $display("FAIL strobe_pulse: got %0b want 0", frame_strobe); else passed++;
    send_word(DATA_A[23:8], 2'b00, 2'b00, 1'b0);
    send_word(DATA_A[39:24], 2'b00, 2'b00, 1'b0);
    total++; if (frame_strobe !== 1'b0) $display("FAIL strobe_w2: got %0b want 0", frame_strobe); else passed++;
    send_word(DATA_A[55:40], 2'b00, 2'b00, 1'b0);
    total++; if (frame_strobe !== 1'b1 || bxn !== 12'd2) $display("FAIL strobe_period: got strobe=%0b bxn=%0d want 1 2", frame_strobe, bxn); else passed++;
  endtask

  task automatic test_valid();
    send_frame(K_NORM, DATA_B, 4'b0000, 1'b0);
    total++; if (valid_clusters !== 4'b1011) $display("FAIL valid_b: got %b want 1011", valid_clusters); else passed++;
    total++; if (cluster2 !== 14'h0600) $display("FAIL cluster2_b: got %h want 0600", cluster2); else passed++;
    send_frame(K_OVF, DATA_A, 4'b0000, 1'b0);
    total++; if (overflow !== 1'b1 || bc0 !== 1'b0) $display("FAIL ovf_flag: got ovf=%0b bc0=%0b want 1 0", overflow, bc0); else passed++;
    total++; if (bxn !== 12'd4) $display("FAIL bxn_ovf: got %0d want 4", bxn); else passed++;
  endtask

  task automatic test_bc0();
    send_frame(K_BC0, DATA_A, 4'b0000, 1'b0);
    total++; if (bc0 !== 1'b1 || bxn !== 12'd0 || bx_err !== 1'b0) $display("FAIL bc0_first: got bc0=%0b bxn=%0d bx_err=%0b want 1 0 0", bc0, bxn, bx_err); else passed++;
    for (int i = 0; i < 3563; i++) send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (bxn !== 12'd3563 || bc0 !== 1'b0) $display("FAIL orbit_end: got bxn=%0d bc0=%0b want 3563 0", bxn, bc0); else passed++;
    send_frame(K_BC0, DATA_A, 4'b0000, 1'b0);
    total++; if (bc0 !== 1'b1 || bxn !== 12'd0 || bx_err !== 1'b0) $display("FAIL bc0_orbit: got bc0=%0b bxn=%0d bx_err=%0b want 1 0 0", bc0, bxn, bx_err); else passed++;
    total++; if (bx_err_cnt !== 16'd0) $display("FAIL bx_cnt_clean: got %0d want 0", bx_err_cnt); else passed++;
    for (int i = 0; i < 100; i++) send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (bxn !== 12'd100) $display("FAIL bxn_100: got %0d want 100", bxn); else passed++;
    send_frame(K_BC0, DATA_A, 4'b0000, 1'b0);
    total++; if (bx_err !== 1'b1 || bxn !== 12'd0) $display("FAIL bx_err_pulse: got bx_err=%0b bxn=%0d want 1 0", bx_err, bxn); else passed++;
    total++; if (bx_err_cnt !== 16'd1) $display("FAIL bx_err_cnt: got %0d want 1", bx_err_cnt); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (bx_err !== 1'b0 || bxn !== 12'd1) $display("FAIL bx_err_clear: got bx_err=%0b bxn=%0d want 0 1", bx_err, bxn); else passed++;
  endtask

  task automatic test_frame_err();
    for (int i = 0; i < 3; i++) begin
      send_frame(K_NORM, DATA_A, 4'b0100, 1'b0);
      total++; if (frame_strobe !== 1'b1 || frame_err !== 1'b1) $display("FAIL ferr_pulse%0d: got strobe=%0b err=%0b want 1 1", i, frame_strobe, frame_err); else passed++;
      total++; if (cluster0 !== 14'h3FFF || cluster3 !== 14'h3FFF || valid_clusters !== 4'b0000) $display("FAIL ferr_invalid%0d: got c0=%h c3=%h v=%b want 3fff 3fff 0000", i, cluster0, cluster3, valid_clusters); else passed++;
    end
    total++; if (locked !== 1'b1) $display("FAIL ferr_still_locked: got %0b want 1", locked); else passed++;
    total++; if (frame_err_cnt !== 16'd3) $display("FAIL ferr_cnt3: got %0d want 3", frame_err_cnt); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (frame_err !== 1'b0 || cluster0 !== 14'h0BCD) $display("FAIL ferr_recover: got err=%0b c0=%h want 0 0bcd", frame_err, cluster0); else passed++;
    for (int i = 1; i <= 4; i++) begin
      send_frame(K_NORM, DATA_A, 4'b0100, 1'b0);
      if (i == 3) begin
        total++; if (locked !== 1'b1) $display("FAIL unlock_early: got %0b want 1", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b0) $display("FAIL unlock: got %0b want 0", locked); else passed++;
    total++; if (frame_err_cnt !== 16'd7) $display("FAIL ferr_cnt7: got %0d want 7", frame_err_cnt); else passed++;
    for (int i = 1; i <= 8; i++) begin
      send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
      if (i == 4) begin
        total++; if (frame_strobe !== 1'b0 || cluster0 !== 14'h3FFF) $display("FAIL unlocked_quiet: got strobe=%0b c0=%h want 0 3fff", frame_strobe, cluster0); else passed++;
      end
      if (i == 7) begin
        total++; if (locked !== 1'b0) $display("FAIL relock_early: got %0b want 0", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b1) $display("FAIL relock: got %0b want 1", locked); else passed++;
  endtask

  task automatic test_cnt_reset();
    send_frame(K_NORM, DATA_A, 4'b0010, 1'b1);
    total++; if (frame_err !== 1'b1) $display("FAIL cr_ferr_pulse: got %0b want 1", frame_err); else passed++;
    total++; if (frame_err_cnt !== 16'd0 || bx_err_cnt !== 16'd0) $display("FAIL cr_clear: got ferr=%0d bxerr=%0d want 0 0", frame_err_cnt, bx_err_cnt); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0010, 1'b0);
    total++; if (frame_err_cnt !== 16'd1) $display("FAIL cr_count_again: got %0d want 1", frame_err_cnt); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
  endtask

  task automatic test_slip();
    send_word(16'h0000, 2'b00, 2'b00, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
      if (i == 3) begin
        total++; if (locked !== 1'b1) $display("FAIL slip_hold: got %0b want 1", locked); else passed++;
      end
      if (i == 4) begin
        total++; if (locked !== 1'b0 || frame_err_cnt !== 16'd5) $display("FAIL slip_unlock: got locked=%0b cnt=%0d want 0 5", locked, frame_err_cnt); else passed++;
      end
      if (i == 11) begin
        total++; if (locked !== 1'b0) $display("FAIL slip_relock_early: got %0b want 0", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b1) $display("FAIL slip_relock: got %0b want 1", locked); else passed++;
    send_frame(K_NORM, DATA_A, 4'b0000, 1'b0);
    total++; if (frame_strobe !== 1'b1 || cluster0 !== 14'h0BCD || bxn !== 12'd1) $display("FAIL slip_data: got strobe=%0b c0=%h bxn=%0d want 1 0bcd 1", frame_strobe, cluster0, bxn); else passed++;
  endtask

  task automatic test_reset_mid();
    send_word({DATA_A[7:0], K_NORM}, 2'b01, 2'b00, 1'b0);
    send_word(DATA_A[23:8], 2'b00, 2'b00, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (locked !== 1'b0 || frame_strobe !== 1'b0) $display("FAIL mid_rst_ctl: got locked=%0b strobe=%0b want 0 0", locked, frame_strobe); else passed++;
    total++; if (cluster0 !== 14'h3FFF || valid_clusters !== 4'b0000) $display("FAIL mid_rst_data: got c0=%h v=%b want 3fff 0000", cluster0, valid_clusters); else passed++;
    total++; if (bxn !== 12'd0 || frame_err_cnt !== 16'd0) $display("FAIL mid_rst_cnt: got bxn=%0d cnt=%0d want 0 0", bxn, frame_err_cnt); else passed++;
    repeat (2) @(posedge clk_160);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_valid();
    test_bc0();
    test_frame_err();
    test_cnt_reset();
    test_slip();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
